// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// Holds register count/width, stall vector layout and the zero constant.
package regfile_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_WIDTH = 32;
    localparam int REG_AW    = 5;
    localparam int STALL_W   = 6;
    localparam int STALL_ID  = 1;

    typedef logic [REG_WIDTH-1:0] reg_t;
    typedef logic [REG_AW-1:0]    raddr_t;
    typedef logic [STALL_W-1:0]   stall_t;
    typedef logic [REG_NUM-1:0]   pend_t;

    localparam reg_t ZERO = '0;

    function automatic logic addr_nz(raddr_t a);
        return a != '0;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register file bus: write-back port, two ID read ports, issue port, stall.
// master = pipeline side (WB/ID), slave = regfile.
interface regfile_if;
    import regfile_pkg::*;

    reg_t   wb_rd_data;
    raddr_t wb_rd_addr;
    logic   wb_rd_enable;
    logic   rs1_read_enable;
    raddr_t rs1_addr;
    logic   rs2_read_enable;
    raddr_t rs2_addr;
    logic   issue_rd_enable;
    raddr_t issue_rd_addr;
    stall_t stall;
    reg_t   rs1_data;
    reg_t   rs2_data;
    logic   stall_req_rf;

    modport master (
        output wb_rd_data, wb_rd_addr, wb_rd_enable,
        output rs1_read_enable, rs1_addr,
        output rs2_read_enable, rs2_addr,
        output issue_rd_enable, issue_rd_addr, stall,
        input  rs1_data, rs2_data, stall_req_rf
    );

    modport slave (
        input  wb_rd_data, wb_rd_addr, wb_rd_enable,
        input  rs1_read_enable, rs1_addr,
        input  rs2_read_enable, rs2_addr,
        input  issue_rd_enable, issue_rd_addr, stall,
        output rs1_data, rs2_data, stall_req_rf
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared on write-back.
// Ports: clk, rst, issue_*_i, wb_*_i in; pending_o (bit 0 always 0) out.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   issue_en_i,
    input  raddr_t issue_addr_i,
    input  logic   issue_hold_i,
    input  logic   wb_en_i,
    input  raddr_t wb_addr_i,
    output pend_t  pending_o
);

    pend_t pending_q;
    pend_t pending_d;

    // Clear is applied before set so a same-address collision
    // leaves the register owned by the newer instruction.
    always_comb begin
        pending_d = pending_q;
        if (wb_en_i && addr_nz(wb_addr_i))
            pending_d[wb_addr_i] = 1'b0;
        if (issue_en_i && addr_nz(issue_addr_i) && !issue_hold_i)
            pending_d[issue_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile.sv
// Integer register file with two combinational read ports and RAW stall.
// Ports: clk, rst, bus (regfile_if.slave). Option: REGFILE_BYPASS_EN.
module regfile
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    reg_t  regs_q [1:REG_NUM-1];
    pend_t pending;
    logic  wb_we;
    logic  rs1_act;
    logic  rs2_act;
    logic  rs1_hit;
    logic  rs2_hit;

    assign wb_we   = bus.wb_rd_enable && addr_nz(bus.wb_rd_addr);
    assign rs1_act = bus.rs1_read_enable && addr_nz(bus.rs1_addr);
    assign rs2_act = bus.rs2_read_enable && addr_nz(bus.rs2_addr);

    // Contents are left to software after reset.
    always_ff @(posedge clk) begin
        if (wb_we)
            regs_q[bus.wb_rd_addr] <= bus.wb_rd_data;
    end

`ifdef REGFILE_BYPASS_EN
    assign rs1_hit = wb_we && (bus.wb_rd_addr == bus.rs1_addr);
    assign rs2_hit = wb_we && (bus.wb_rd_addr == bus.rs2_addr);
`else
    assign rs1_hit = 1'b0;
    assign rs2_hit = 1'b0;
`endif

    always_comb begin
        bus.rs1_data = ZERO;
        if (!rst && rs1_act)
            bus.rs1_data = rs1_hit ? bus.wb_rd_data : regs_q[bus.rs1_addr];
    end

    always_comb begin
        bus.rs2_data = ZERO;
        if (!rst && rs2_act)
            bus.rs2_data = rs2_hit ? bus.wb_rd_data : regs_q[bus.rs2_addr];
    end

    assign bus.stall_req_rf = !rst && (
        (rs1_act && pending[bus.rs1_addr] && !rs1_hit) ||
        (rs2_act && pending[bus.rs2_addr] && !rs2_hit));

    regfile_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_en_i   (bus.issue_rd_enable),
        .issue_addr_i (bus.issue_rd_addr),
        .issue_hold_i (bus.stall[STALL_ID]),
        .wb_en_i      (bus.wb_rd_enable),
        .wb_addr_i    (bus.wb_rd_addr),
        .pending_o    (pending)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reads, x0, bypass, scoreboard, reset.
// Build with or without REGFILE_BYPASS_EN; expectations follow it.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_if rf_if ();

    regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.wb_rd_enable    = 1'b0;
        rf_if.wb_rd_addr      = '0;
        rf_if.wb_rd_data      = '0;
        rf_if.rs1_read_enable = 1'b0;
        rf_if.rs1_addr        = '0;
        rf_if.rs2_read_enable = 1'b0;
        rf_if.rs2_addr        = '0;
        rf_if.issue_rd_enable = 1'b0;
        rf_if.issue_rd_addr   = '0;
        rf_if.stall           = '0;
    endtask

    task automatic wb(input raddr_t a, input reg_t d);
        rf_if.wb_rd_enable = 1'b1;
        rf_if.wb_rd_addr   = a;
        rf_if.wb_rd_data   = d;
    endtask

    task automatic issue(input raddr_t a);
        rf_if.issue_rd_enable = 1'b1;
        rf_if.issue_rd_addr   = a;
    endtask

    task automatic rd1(input raddr_t a);
        rf_if.rs1_read_enable = 1'b1;
        rf_if.rs1_addr        = a;
    endtask

    task automatic rd2(input raddr_t a);
        rf_if.rs2_read_enable = 1'b1;
        rf_if.rs2_addr        = a;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd1(5'd5);
        #1;
        chk("rst_rs1_c0", rf_if.rs1_data, 32'h0);
        chk("rst_stall_c0", {31'b0, rf_if.stall_req_rf}, 32'h0);
        tick();
        chk("rst_rs1_c1", rf_if.rs1_data, 32'h0);
        chk("rst_stall_c1", {31'b0, rf_if.stall_req_rf}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);

        // write x7, read back on both ports
        idle();
        wb(5'd7, 32'hDEADBEEF);
        tick();
        idle();
        rd1(5'd7);
        rd2(5'd7);
        #1;
        chk("rd_x7_p1", rf_if.rs1_data, 32'hDEADBEEF);
        chk("rd_x7_p2", rf_if.rs2_data, 32'hDEADBEEF);
        rf_if.rs1_read_enable = 1'b0;
        #1;
        chk("rd_dis_p1", rf_if.rs1_data, 32'h0);

        // x0 write is dropped
        idle();
        wb(5'd0, 32'h00001234);
        tick();
        idle();
        rd2(5'd0);
        #1;
        chk("rd_x0", rf_if.rs2_data, 32'h0);

        // same-cycle write-back of an issued register
        issue(5'd3);
        tick();
        idle();
        rd1(5'd3);
        wb(5'd3, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_x3_data", rf_if.rs1_data, 32'h55);
        chk("byp_x3_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);
`else
        chk("nobyp_x3_stall", {31'b0, rf_if.stall_req_rf}, 32'h1);
`endif
        tick();
        idle();
        rd1(5'd3);
        #1;
        chk("x3_next_data", rf_if.rs1_data, 32'h55);
        chk("x3_next_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);

        // scoreboard holds x9 until its write-back
        idle();
        issue(5'd9);
        #1;
        chk("issue_no_self_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);
        tick();
        idle();
        rd2(5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("x9_stall_%0d", i),
                {31'b0, rf_if.stall_req_rf}, 32'h1);
            tick();
        end
        wb(5'd9, 32'h99);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x9_wb_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);
        chk("x9_wb_data", rf_if.rs2_data, 32'h99);
`else
        chk("x9_wb_stall", {31'b0, rf_if.stall_req_rf}, 32'h1);
`endif
        tick();
        idle();
        rd2(5'd9);
        #1;
        chk("x9_after_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);
        chk("x9_after_data", rf_if.rs2_data, 32'h99);

        // set wins over clear on the same address
        idle();
        issue(5'd4);
        tick();
        idle();
        issue(5'd4);
        wb(5'd4, 32'h44);
        tick();
        idle();
        rd1(5'd4);
        #1;
        chk("x4_coll_stall", {31'b0, rf_if.stall_req_rf}, 32'h1);
        chk("x4_coll_data", rf_if.rs1_data, 32'h44);

        // different addresses on the same edge: both apply
        idle();
        wb(5'd4, 32'h45);
        issue(5'd10);
        tick();
        idle();
        rd1(5'd4);
        #1;
        chk("x4_cleared", {31'b0, rf_if.stall_req_rf}, 32'h0);
        idle();
        rd2(5'd10);
        #1;
        chk("x10_pending", {31'b0, rf_if.stall_req_rf}, 32'h1);
        idle();
        wb(5'd10, 32'hA);
        tick();

        // issue gated only by the ID stall bit
        idle();
        issue(5'd12);
        rf_if.stall = 6'b000010;
        tick();
        idle();
        rd1(5'd12);
        #1;
        chk("x12_gated", {31'b0, rf_if.stall_req_rf}, 32'h0);
        idle();
        issue(5'd13);
        rf_if.stall = 6'b000001;
        tick();
        idle();
        rd1(5'd13);
        #1;
        chk("x13_not_gated", {31'b0, rf_if.stall_req_rf}, 32'h1);

        // reset mid-operation clears pending and masks outputs
        idle();
        issue(5'd20);
        tick();
        idle();
        rd1(5'd20);
        rd2(5'd7);
        #1;
        chk("x20_pending", {31'b0, rf_if.stall_req_rf}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, rf_if.stall_req_rf}, 32'h0);
        chk("mid_rst_rs2", rf_if.rs2_data, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("x20_after_rst", {31'b0, rf_if.stall_req_rf}, 32'h0);
        idle();
        rd2(5'd13);
        #1;
        chk("x13_after_rst", {31'b0, rf_if.stall_req_rf}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
